// File: rtl/cpu_pkg.sv
// Shared CPU pipeline types: datapath widths, memory-stage FSM states and the
// MEM/WB bundle consumed by write-back.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  typedef struct packed {
    logic              RegWrite;
    logic              MemToReg;
    logic              ret;
    logic [REG_W-1:0]  DestReg;
    logic [DATA_W-1:0] ALU;
    logic [DATA_W-1:0] MemData;
  } memwb_t;

endpackage

// File: rtl/mem_access_stage_memwb_reg.sv
// MEM/WB pipeline register: async-reset bundle flop; bubble loads an all-zero
// (no-write, no-ret) entry.
module MEMWB_reg
  import cpu_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  memwb_t d,
  input  logic   bubble,
  output memwb_t q
);

  // MEM/WB state: bubble overrides the incoming bundle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: req/ack data-memory transaction for load/store/ret, upstream
// stall, MEM/WB register. Define MEM_TIMEOUT_EN to abort accesses that never ack.
module mem_access_stage #(
  parameter int DATA_W         = cpu_pkg::DATA_W,
  parameter int REG_W          = cpu_pkg::REG_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWrite_in,
  input  logic              MemWrite_in,
  input  logic              MemRead_in,
  input  logic              MemToReg_in,
  input  logic              MemSrc_in,
  input  logic              ret_in,
  input  logic [REG_W-1:0]  DestReg_in,
  input  logic [DATA_W-1:0] EX_in,
  input  logic [DATA_W-1:0] MemWrite_data_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_stack,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_out,
  output logic              RegWrite_out,
  output logic              MemToReg_out,
  output logic              ret_out,
  output logic [REG_W-1:0]  DestReg_out,
  output logic [DATA_W-1:0] ALU_out,
  output logic [DATA_W-1:0] MemData_out,
  output logic              mem_err_out
);
  import cpu_pkg::*;

  mem_state_t        state_r, state_nxt_s;
  logic [DATA_W-1:0] addr_r, wdata_r;
  logic [REG_W-1:0]  dest_r;
  logic              we_r, stack_r, regwrite_r, memtoreg_r, ret_r;
  logic              mem_op_s, capture_s, bubble_s, stall_s, timeout_s;
  logic              err_r, err_nxt_s;
  memwb_t            wb_s, wb_q_s;

  assign mem_op_s = MemRead_in | MemWrite_in | ret_in;

  // FSM state and one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  // Captured transaction; held unchanged for the whole access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= {DATA_W{1'b0}};
      wdata_r    <= {DATA_W{1'b0}};
      dest_r     <= {REG_W{1'b0}};
      we_r       <= 1'b0;
      stack_r    <= 1'b0;
      regwrite_r <= 1'b0;
      memtoreg_r <= 1'b0;
      ret_r      <= 1'b0;
    end else if (capture_s) begin
      addr_r     <= EX_in;
      wdata_r    <= MemWrite_data_in;
      dest_r     <= DestReg_in;
      we_r       <= MemWrite_in;
      stack_r    <= MemSrc_in;
      regwrite_r <= RegWrite_in;
      memtoreg_r <= MemToReg_in;
      ret_r      <= ret_in;
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;

  // ACCESS cycles spent without ack; restarts on every new access
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (capture_s) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ACCESS) && !mem_ack) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign timeout_s = (state_r == ACCESS) && (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // Next state, stall, capture and the bundle offered to MEM/WB
  always_comb begin
    state_nxt_s = state_r;
    stall_s     = 1'b0;
    capture_s   = 1'b0;
    bubble_s    = 1'b1;
    err_nxt_s   = 1'b0;
    wb_s        = '0;
    case (state_r)
      IDLE: begin
        if (mem_op_s) begin
          state_nxt_s = ACCESS;
          stall_s     = 1'b1;
          capture_s   = 1'b1;
        end else begin
          bubble_s     = 1'b0;
          wb_s.RegWrite = RegWrite_in;
          wb_s.MemToReg = MemToReg_in;
          wb_s.ret      = ret_in;
          wb_s.DestReg  = DestReg_in;
          wb_s.ALU      = EX_in;
          wb_s.MemData  = {DATA_W{1'b0}};
        end
      end
      ACCESS: begin
        wb_s.MemToReg = memtoreg_r;
        wb_s.DestReg  = dest_r;
        wb_s.ALU      = addr_r;
        if (mem_ack) begin
          state_nxt_s   = IDLE;
          bubble_s      = 1'b0;
          wb_s.RegWrite = regwrite_r;
          wb_s.ret      = ret_r;
          wb_s.MemData  = we_r ? {DATA_W{1'b0}} : mem_rdata;
        end else if (timeout_s) begin
          // Abort: pass the op down without any architectural write
          state_nxt_s = IDLE;
          bubble_s    = 1'b0;
          err_nxt_s   = 1'b1;
        end else begin
          stall_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  MEMWB_reg u_memwb (
    .clk    (clk),
    .rst    (rst),
    .d      (wb_s),
    .bubble (bubble_s),
    .q      (wb_q_s)
  );

  assign mem_req      = (state_r == ACCESS);
  assign mem_we       = we_r;
  assign mem_stack    = stack_r;
  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign stall_out    = stall_s;
  assign mem_err_out  = err_r;
  assign RegWrite_out = wb_q_s.RegWrite;
  assign MemToReg_out = wb_q_s.MemToReg;
  assign ret_out      = wb_q_s.ret;
  assign DestReg_out  = wb_q_s.DestReg;
  assign ALU_out      = wb_q_s.ALU;
  assign MemData_out  = wb_q_s.MemData;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed steps then random ops
// against a per-operation expectation model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, MemSrc_in, ret_in;
  logic [4:0]  DestReg_in;
  logic [31:0] EX_in, MemWrite_data_in, mem_rdata;
  logic        mem_ack;
  logic        mem_req, mem_we, mem_stack, stall_out;
  logic [31:0] mem_addr, mem_wdata;
  logic        RegWrite_out, MemToReg_out, ret_out, mem_err_out;
  logic [4:0]  DestReg_out;
  logic [31:0] ALU_out, MemData_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DATA_W(32), .REG_W(5), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .MemToReg_in(MemToReg_in), .MemSrc_in(MemSrc_in), .ret_in(ret_in),
    .DestReg_in(DestReg_in), .EX_in(EX_in), .MemWrite_data_in(MemWrite_data_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_stack(mem_stack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_out(stall_out), .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .ret_out(ret_out), .DestReg_out(DestReg_out), .ALU_out(ALU_out),
    .MemData_out(MemData_out), .mem_err_out(mem_err_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rw, mtr, mr, mw, src, rt,
                        input logic [4:0] dest, input logic [31:0] ex, wd);
    RegWrite_in = rw; MemToReg_in = mtr; MemRead_in = mr; MemWrite_in = mw;
    MemSrc_in = src; ret_in = rt; DestReg_in = dest; EX_in = ex; MemWrite_data_in = wd;
  endtask

  // One instruction through the stage; d = ACCESS cycles without ack before the ack cycle.
  // Entered and left at a falling edge.
  task automatic do_op(input logic rw, mtr, mr, mw, src, rt,
                       input logic [4:0] dest, input logic [31:0] ex, wd, rd, input int d);
    logic op;
    int   stalls;
    op = mr | mw | rt;
    set_in(rw, mtr, mr, mw, src, rt, dest, ex, wd);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    chk("idle_stall", {31'd0, stall_out}, {31'd0, op});
    chk("idle_req", {31'd0, mem_req}, 32'd0);
    stalls = stall_out ? 1 : 0;
    @(negedge clk);
    if (op) begin
      for (int i = 0; i <= d; i++) begin
        EX_in = $urandom; MemWrite_data_in = $urandom; DestReg_in = 5'($urandom);
        RegWrite_in = 1'($urandom_range(0, 1));
        mem_ack   = (i == d);
        mem_rdata = (i == d) ? rd : $urandom;
        #1;
        chk("acc_req", {31'd0, mem_req}, 32'd1);
        chk("acc_addr", mem_addr, ex);
        chk("acc_wdata", mem_wdata, wd);
        chk("acc_we", {31'd0, mem_we}, {31'd0, mw});
        chk("acc_stack", {31'd0, mem_stack}, {31'd0, src});
        chk("acc_stall", {31'd0, stall_out}, {31'd0, (i < d)});
        chk("acc_bubble", {30'd0, RegWrite_out, ret_out}, 32'd0);
        if (stall_out) stalls++;
        @(negedge clk);
      end
      mem_ack = 1'b0;
      chk("stall_cycles", 32'(stalls), 32'(d + 1));
    end
    chk("wb_regwrite", {31'd0, RegWrite_out}, {31'd0, rw});
    chk("wb_memtoreg", {31'd0, MemToReg_out}, {31'd0, mtr});
    chk("wb_ret", {31'd0, ret_out}, {31'd0, rt});
    chk("wb_dest", {27'd0, DestReg_out}, {27'd0, dest});
    chk("wb_alu", ALU_out, ex);
    chk("wb_memdata", MemData_out, (op && !mw) ? rd : 32'd0);
    chk("wb_req_low", {31'd0, mem_req}, 32'd0);
    chk("wb_err", {31'd0, mem_err_out}, 32'd0);
  endtask

  initial begin
    int kind;
    logic [31:0] ex;
    rst = 1'b1; mem_ack = 1'b0; mem_rdata = 32'd0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_wb", {29'd0, RegWrite_out, MemToReg_out, ret_out}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_memdata", MemData_out, 32'd0);
    rst = 1'b0;

    // directed steps
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0, 32'h0, 0);
    do_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd7, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    do_op(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h200, 32'hA5A5A5A5, 32'h0, 0);
    do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'hFFF0, 32'h0, 32'h40, 1);
    do_op(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h104, 32'h0, 32'h12345678, 2);

    // reset in the middle of an access
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 32'h300, 32'h0);
    @(negedge clk);
    #1 chk("mid_req_before", {31'd0, mem_req}, 32'd1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, mem_req}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_stall", {31'd0, stall_out}, 32'd0);
    #1 rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("late_ack_req", {31'd0, mem_req}, 32'd0);
    chk("late_ack_data", MemData_out, 32'd0);
    mem_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
    // no ack: abort after 4 ACCESS cycles
    set_in(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 32'h400, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_req", {31'd0, mem_req}, 32'd1);
      chk("to_stall", {31'd0, stall_out}, {31'd0, (i < 3)});
      @(negedge clk);
    end
    chk("to_req_drop", {31'd0, mem_req}, 32'd0);
    chk("to_err", {31'd0, mem_err_out}, 32'd1);
    chk("to_wb", {30'd0, RegWrite_out, ret_out}, 32'd0);
    chk("to_memdata", MemData_out, 32'd0);
    chk("to_alu", ALU_out, 32'h400);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
    @(negedge clk);
    chk("to_err_pulse", {31'd0, mem_err_out}, 32'd0);
`endif

    // random ops (ack delay bounded to 3 so an enabled timeout never fires)
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      ex   = $urandom;
      case (kind)
        0: do_op(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                 5'($urandom), ex, $urandom, 32'd0, 0);
        1: do_op(1'b1, 1'b1, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0,
                 5'($urandom), ex, $urandom, $urandom, $urandom_range(0, 3));
        2: do_op(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0,
                 5'($urandom), ex, $urandom, $urandom, $urandom_range(0, 3));
        default: do_op(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                       5'd0, ex, 32'd0, $urandom, $urandom_range(0, 3));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
